imem_loader: RTL

Hardware program loader for the pipelined RISC-V core's instruction memory. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit little-endian instruction words. Each word is written into imem word by word, starting at word address 0, while the CPU is held in reset. On the all-zero terminator word it writes that word, then releases the CPU.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_word_assembler.sv | 64 ++++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               state_t         - loader FSM state encoding
//               WORD_BYTES      - bytes per instruction word
//               BYTE_IDX_W      - width of the byte-within-word index
//               TERMINATOR_WORD - word value that ends a load session
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int          WORD_BYTES      = 4;
  localparam int          BYTE_IDX_W      = $clog2(WORD_BYTES);
  localparam logic [31:0] TERMINATOR_WORD = 32'h0000_0000;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs a little-endian byte stream into 32-bit words.
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   clear      in   restart assembly at byte 0 with an empty word
//   byte_valid in   a byte is accepted this cycle
//   byte_data  in   accepted byte
//   last_byte  out  the next accepted byte completes the word
//   word       out  assembled word (registered)
//   word_valid out  one-cycle strobe: word holds a complete word
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]           word_q, word_d;
  logic                  word_valid_q, word_valid_d;

  assign last_byte  = (byte_idx_q == BYTE_IDX_W'(WORD_BYTES - 1));
  assign word       = word_q;
  assign word_valid = word_valid_q;

  always_comb begin
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      byte_idx_d = '0;
      word_d     = '0;
    end else if (byte_valid) begin
      // Byte k lands in bits [8k+7:8k]; the index wraps after the last byte.
      word_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
      byte_idx_d   = byte_idx_q + BYTE_IDX_W'(1);
      word_valid_d = last_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule : byte_word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a program into instruction memory from a byte stream
//               while holding the CPU in reset; releases the CPU after the
//               all-zero terminator word has been written.
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   single-cycle pulse, begins a load session
//   in_valid   in   byte-stream valid
//   in_data    in   stream byte, LSB of each word first
//   in_ready   out  a byte can be accepted this cycle
//   imem_we    out  one-cycle instruction-memory write enable
//   imem_addr  out  word address of the write
//   imem_wdata out  instruction word to write
//   cpu_reset  out  holds the CPU in reset while high
//   load_done  out  load completed with a terminator
//   load_error out  capacity exhausted without a terminator
//   word_count out  words written this session, terminator included
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(MAX_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_count_one = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;

  logic                  accept;
  logic                  asm_clear;
  logic                  asm_last;
  logic [31:0]           asm_word;
  logic                  asm_word_valid;

  assign accept = in_valid & in_ready_q;

  byte_word_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (accept),
    .byte_data  (in_data),
    .last_byte  (asm_last),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

  // The assembler's registered word/strobe coincide with the WRITE state.
  assign imem_we    = asm_word_valid;
  assign imem_wdata = asm_word;
  assign imem_addr  = addr_q;
  assign in_ready   = in_ready_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_count = count_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    asm_clear = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = RECV;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
        end
      end
      RECV: begin
        if (accept && asm_last) state_d = WRITE;
      end
      WRITE: begin
        count_d = count_q + c_count_one;
        // The terminator check precedes the capacity check so a terminator
        // in the last slot still completes the load.
        if (asm_word == TERMINATOR_WORD) begin
          state_d = DONE;
        end else if (addr_q == c_last_addr) begin
          state_d = ERROR;
        end else begin
          addr_d  = addr_q + c_addr_one;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    in_ready_d   = (state_d == RECV);
    cpu_reset_d  = (state_d != DONE);
    load_done_d  = (state_d == DONE);
    load_error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

endmodule : imem_loader
`default_nettype wire
